uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side buffer between a UART receiver and its consumer.
//                A small ingest FSM captures one character per RX_DV high
//                period into a first-word fall-through FIFO. It acknowledges
//                the upstream receiver with a one-cycle RX_CLR_DV pulse.
//                Characters arriving while the FIFO is full are dropped, still
//                acknowledged, and flagged on the sticky OVERRUN output.
//  Ports       : CLK, RST            - clock, synchronous active-high reset
//                RX_DATA, RX_DV      - character and data-valid from receiver
//                RX_CLR_DV           - one-cycle acknowledge to receiver
//                POP, DOUT           - consumer read strobe, head character
//                EMPTY, FULL, COUNT  - FIFO occupancy
//                OVERRUN, CLR_OVR    - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int BITS       = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BITS-1:0]       RX_DATA,
    input  logic                  RX_DV,
    output logic                  RX_CLR_DV,
    input  logic                  POP,
    output logic [BITS-1:0]       DOUT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERRUN,
    input  logic                  CLR_OVR
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACK  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [BITS-1:0]       r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_space;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_clr_dv;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);
    // A pop on an empty FIFO is ignored entirely.
    assign w_pop   = POP && !w_empty;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign w_space = !w_full || w_pop;

    // ------------------------------------------------------------------
    // Ingest FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        w_clr_dv    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (RX_DV) begin
                    // Dropped characters are acknowledged too so the
                    // receiver never stalls.
                    if (w_space) begin
                        w_wr = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    w_state_nxt = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                w_clr_dv    = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // Wait for the DV level to fall so one high period yields
                // at most one character.
                if (!RX_DV) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents intentionally not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && w_wr) begin
            r_mem[r_wr_ptr] <= RX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set wins over clear so a drop is never lost to a coincident clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (CLR_OVR) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RX_CLR_DV = w_clr_dv;
    assign DOUT      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign EMPTY     = w_empty;
    assign FULL      = w_full;
    assign COUNT     = r_count;
    assign OVERRUN   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Directed stimulus
//                pushes each character it expects to be stored into a
//                scoreboard queue; an independent monitor compares DOUT
//                against the queue head on every accepted pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_DATA;
    logic       RX_DV;
    logic       RX_CLR_DV;
    logic       POP;
    logic [7:0] DOUT;
    logic       EMPTY;
    logic       FULL;
    logic [3:0] COUNT;
    logic       OVERRUN;
    logic       CLR_OVR;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];

    uart_rx_fifo #(
        .BITS       (8),
        .DEPTH_LOG2 (3)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_DV     (RX_DV),
        .RX_CLR_DV (RX_CLR_DV),
        .POP       (POP),
        .DOUT      (DOUT),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .COUNT     (COUNT),
        .OVERRUN   (OVERRUN),
        .CLR_OVR   (CLR_OVR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One upstream handshake. The acknowledge must appear in exactly the
    // cycle after the capturing edge and last one cycle.
    task automatic send_char(input logic [7:0] d, input bit accept,
                             input bit with_pop, input bit with_clr);
        RX_DATA = d;
        RX_DV   = 1'b1;
        POP     = with_pop;
        CLR_OVR = with_clr;
        if (accept) sb.push_back(d);
        step();
        POP     = 1'b0;
        CLR_OVR = 1'b0;
        check("ack_pulse", {31'd0, RX_CLR_DV}, 32'd1);
        step();
        check("ack_end", {31'd0, RX_CLR_DV}, 32'd0);
        RX_DV = 1'b0;
        step();
    endtask

    task automatic pop_n(input int n);
        POP = 1'b1;
        repeat (n) step();
        POP = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, between driving edges.
    always @(negedge CLK) begin
        if (!RST && POP && !EMPTY) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h with empty scoreboard", DOUT);
            end else begin
                check("pop_data", {24'd0, DOUT}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit held_ok;
        RST = 1'b1; RX_DATA = 8'h00; RX_DV = 1'b0; POP = 1'b0; CLR_OVR = 1'b0;
        step();
        step();
        RST = 1'b0;
        check("rst_count",   {28'd0, COUNT},     32'd0);
        check("rst_empty",   {31'd0, EMPTY},     32'd1);
        check("rst_full",    {31'd0, FULL},      32'd0);
        check("rst_overrun", {31'd0, OVERRUN},   32'd0);
        check("rst_clr_dv",  {31'd0, RX_CLR_DV}, 32'd0);
        check("rst_dout",    {24'd0, DOUT},      32'd0);

        // Single byte.
        send_char(8'h5A, 1'b1, 1'b0, 1'b0);
        check("single_empty", {31'd0, EMPTY}, 32'd0);
        check("single_count", {28'd0, COUNT}, 32'd1);
        check("single_dout",  {24'd0, DOUT},  32'h5A);
        pop_n(1);
        check("single_popped_empty", {31'd0, EMPTY}, 32'd1);
        check("single_popped_dout",  {24'd0, DOUT},  32'd0);

        // Fill and wrap.
        for (int i = 1; i <= 8; i++) send_char(8'(i), 1'b1, 1'b0, 1'b0);
        check("fill_full",  {31'd0, FULL},  32'd1);
        check("fill_count", {28'd0, COUNT}, 32'd8);
        pop_n(3);
        for (int i = 9; i <= 11; i++) send_char(8'(i), 1'b1, 1'b0, 1'b0);
        check("wrap_count", {28'd0, COUNT}, 32'd8);

        // Overrun while full.
        send_char(8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovr_count", {28'd0, COUNT},   32'd8);
        check("ovr_set",   {31'd0, OVERRUN}, 32'd1);
        CLR_OVR = 1'b1;
        step();
        CLR_OVR = 1'b0;
        check("ovr_clear", {31'd0, OVERRUN}, 32'd0);
        send_char(8'hEE, 1'b0, 1'b0, 1'b1);
        check("ovr_set_beats_clr", {31'd0, OVERRUN}, 32'd1);
        CLR_OVR = 1'b1;
        step();
        CLR_OVR = 1'b0;
        check("ovr_clear2", {31'd0, OVERRUN}, 32'd0);
        pop_n(8);
        check("drain_empty", {31'd0, EMPTY}, 32'd1);

        // Full plus simultaneous pop and write.
        for (int i = 1; i <= 8; i++) send_char(8'(i), 1'b1, 1'b0, 1'b0);
        send_char(8'h77, 1'b1, 1'b1, 1'b0);
        check("popwr_count", {28'd0, COUNT}, 32'd8);
        check("popwr_head",  {24'd0, DOUT},  32'h02);
        pop_n(8);
        check("popwr_empty", {31'd0, EMPTY}, 32'd1);

        // DV held high long after the acknowledge.
        RX_DATA = 8'h33;
        RX_DV   = 1'b1;
        sb.push_back(8'h33);
        step();
        check("held_ack", {31'd0, RX_CLR_DV}, 32'd1);
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (RX_CLR_DV !== 1'b0 || COUNT !== 4'd1) held_ok = 1'b0;
        end
        check("held_single_entry", {31'd0, held_ok}, 32'd1);
        RX_DV = 1'b0;
        step();
        send_char(8'h44, 1'b1, 1'b0, 1'b0);
        check("held_then_next_count", {28'd0, COUNT}, 32'd2);
        pop_n(2);

        // Reset in the middle of a handshake.
        for (int i = 0; i < 5; i++) send_char(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("mid_count5", {28'd0, COUNT}, 32'd5);
        RX_DATA = 8'h55;
        RX_DV   = 1'b1;
        step();
        check("mid_in_ack", {31'd0, RX_CLR_DV}, 32'd1);
        RST = 1'b1; POP = 1'b1; CLR_OVR = 1'b1;
        step();
        RST = 1'b0; POP = 1'b0; CLR_OVR = 1'b0;
        sb.delete();
        check("mid_rst_count",   {28'd0, COUNT},     32'd0);
        check("mid_rst_empty",   {31'd0, EMPTY},     32'd1);
        check("mid_rst_clr_dv",  {31'd0, RX_CLR_DV}, 32'd0);
        check("mid_rst_overrun", {31'd0, OVERRUN},   32'd0);
        sb.push_back(8'h55);
        step();
        check("post_rst_new_ack",   {31'd0, RX_CLR_DV}, 32'd1);
        check("post_rst_new_count", {28'd0, COUNT},     32'd1);
        step();
        RX_DV = 1'b0;
        step();
        pop_n(1);
        pop_n(1);
        check("empty_pop_count", {28'd0, COUNT}, 32'd0);
        check("empty_pop_empty", {31'd0, EMPTY}, 32'd1);
        send_char(8'h66, 1'b1, 1'b0, 1'b0);
        pop_n(1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
